// File: rtl/mem_clear_ctrl_if.sv
// Command handshake between a host and the memory-clear controller.
// The host drives a two-bit opcode with req_valid; the controller answers with req_ready.
interface mem_clear_ctrl_if;
   logic       req_valid;
   logic [1:0] req_op;
   logic       req_ready;

   modport master (
      output req_valid,
      output req_op,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_op,
      output req_ready
   );
endinterface

// File: rtl/mem_clear_ctrl.sv
// Sequencer for the address-range memory datapath.
// - Loads the datapath's low and high address registers.
// - Issues single host writes.
// - Runs the inclusive zero-fill sweep from low up to high. The counter wraps
//   at 2**ADDRWIDTH.
// All strobes are Mealy outputs of the state and the current inputs.
module mem_clear_ctrl #(
   parameter int ADDRWIDTH = 6
) (
   input  logic                 clock,
   input  logic                 reset_n,
   mem_clear_ctrl_if.slave      req,
   input  logic                 abort,
   input  logic                 cnt_eq,
   output logic                 ld_low,
   output logic                 ld_high,
   output logic                 write,
   output logic                 ld_cnt,
   output logic                 cnt_en,
   output logic                 addr_sel,
   output logic                 zero_we,
   output logic                 set_busy,
   output logic                 clr_busy,
   output logic                 done,
   output logic                 aborted,
   output logic [ADDRWIDTH:0]   zero_cnt
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ZERO = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [1:0] OP_WRITE      = 2'b00;
   localparam logic [1:0] OP_LOAD_LOW   = 2'b01;
   localparam logic [1:0] OP_LOAD_HIGH  = 2'b10;
   localparam logic [1:0] OP_ZERO_RANGE = 2'b11;

   // One extra bit lets a full 2**ADDRWIDTH sweep be counted without overflow.
   localparam logic [ADDRWIDTH:0] CNT_ONE = 1;

   logic [1:0] state;
   logic [1:0] state_next;
   logic       ready;
   logic       accept_zero;

   assign req.req_ready = ready;

   // Next-state and control-strobe decode. Reset forces the idle, busy-clearing output set.
   always_comb begin
      // NOTE: every output gets a default first, so no path through the case leaves a latch.
      state_next  = state;
      ready       = 1'b0;
      accept_zero = 1'b0;
      ld_low      = 1'b0;
      ld_high     = 1'b0;
      write       = 1'b0;
      ld_cnt      = 1'b0;
      cnt_en      = 1'b0;
      addr_sel    = 1'b0;
      zero_we     = 1'b0;
      set_busy    = 1'b0;
      clr_busy    = 1'b0;
      done        = 1'b0;

      if (!reset_n) begin
         clr_busy   = 1'b1;
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               ready = 1'b1;
               if (req.req_valid) begin
                  case (req.req_op)
                     OP_WRITE:     write   = 1'b1;
                     OP_LOAD_LOW:  ld_low  = 1'b1;
                     OP_LOAD_HIGH: ld_high = 1'b1;
                     OP_ZERO_RANGE: begin
                        ld_cnt      = 1'b1;
                        set_busy    = 1'b1;
                        accept_zero = 1'b1;
                        state_next  = ZERO;
                     end
                     default: ;
                  endcase
               end
            end
            ZERO: begin
               addr_sel = 1'b1;
               if (abort) begin
                  // Abort wins over cnt_eq: the current address is not written.
                  state_next = DONE;
               end else begin
                  zero_we = 1'b1;
                  if (cnt_eq) state_next = DONE;
                  else        cnt_en     = 1'b1;
               end
            end
            DONE: begin
               clr_busy   = 1'b1;
               done       = 1'b1;
               state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // State register and the sweep result registers (write count and abort flag).
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments, so every register updates from pre-edge values.
      if (!reset_n) begin
         state    <= IDLE;
         aborted  <= 1'b0;
         zero_cnt <= '0;
      end else begin
         state <= state_next;
         if (accept_zero) begin
            zero_cnt <= '0;
            aborted  <= 1'b0;
         end else if (state == ZERO) begin
            if (abort) aborted  <= 1'b1;
            else       zero_cnt <= zero_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_mem_clear_ctrl.sv
// Self-checking bench for mem_clear_ctrl.
// A behavioural datapath holds the low/high registers, the counter, a 64x8 memory
// and the busy JK flip-flop. It is driven by the controller's strobes.
// Sweep results go through a scoreboard queue that is popped on each done pulse.
module tb_mem_clear_ctrl;
   localparam int AW    = 6;
   localparam int DEPTH = 64;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_LOW   = 2'b01;
   localparam logic [1:0] OP_HIGH  = 2'b10;
   localparam logic [1:0] OP_ZERO  = 2'b11;

   logic          clock   = 1'b0;
   logic          reset_n = 1'b0;
   logic          abort   = 1'b0;
   logic [AW-1:0] addr    = '0;
   logic [7:0]    din     = '0;
   logic          cnt_eq;
   logic          ld_low, ld_high, write, ld_cnt, cnt_en, addr_sel, zero_we;
   logic          set_busy, clr_busy, done, aborted;
   logic [AW:0]   zero_cnt;

   mem_clear_ctrl_if req_if ();

   mem_clear_ctrl #(.ADDRWIDTH(AW)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .req      (req_if),
      .abort    (abort),
      .cnt_eq   (cnt_eq),
      .ld_low   (ld_low),
      .ld_high  (ld_high),
      .write    (write),
      .ld_cnt   (ld_cnt),
      .cnt_en   (cnt_en),
      .addr_sel (addr_sel),
      .zero_we  (zero_we),
      .set_busy (set_busy),
      .clr_busy (clr_busy),
      .done     (done),
      .aborted  (aborted),
      .zero_cnt (zero_cnt)
   );

   always #5 clock = ~clock;

   // Behavioural datapath model
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] low_reg  = '0;
   logic [AW-1:0] high_reg = '0;
   logic [AW-1:0] cnt      = '0;
   logic          busy     = 1'b1;
   logic          fill_req = 1'b0;

   assign cnt_eq = (cnt == high_reg);

   // Datapath register updates on the rising edge
   always @(posedge clock) begin
      if (fill_req)
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
      if (ld_low)  low_reg  <= addr;
      if (ld_high) high_reg <= addr;
      if (write && !addr_sel) mem[addr] <= din;
      if (ld_cnt)      cnt <= low_reg;
      else if (cnt_en) cnt <= cnt + 1'b1;
      if (zero_we && addr_sel) mem[cnt] <= 8'h00;
      case ({set_busy, clr_busy})
         2'b10:   busy <= 1'b1;
         2'b01:   busy <= 1'b0;
         2'b11:   busy <= ~busy;
         default: ;
      endcase
   end

   // Checking infrastructure
   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      int   writes;
      logic ab;
      int   done_cyc;
   } exp_t;

   exp_t sb[$];
   int   we_cnt     = 0;
   int   done_seen  = 0;
   int   both_seen  = 0;

   // Monitor: counts sweep writes and scores each done pulse against the scoreboard
   always @(negedge clock) begin
      if (ld_cnt) we_cnt = 0;
      if (zero_we) we_cnt++;
      if (set_busy && clr_busy) both_seen++;
      if (done) begin
         done_seen++;
         if (sb.size() == 0) begin
            check("unexpected done", sb.size(), 1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done zero_cnt", zero_cnt, e.writes);
            check("done aborted", aborted, e.ab);
            check("done write count", we_cnt, e.writes);
            check("done cycle", cyc, e.done_cyc);
            check("done req_ready", req_if.req_ready, 0);
         end
      end
   end

   typedef struct {
      logic       valid;
      logic [1:0] op;
      logic [5:0] a;
      logic [7:0] d;
      logic       ab;
      logic       e_low;
      logic       e_high;
      logic       e_write;
      logic       e_ready;
   } vec_t;

   typedef struct {
      int   low;
      int   high;
      int   abort_at;
      int   writes;
      logic ab;
   } sw_t;

   vec_t vecs[4];
   sw_t  sweeps[5];

   initial begin
      int bad;
      int off;
      int d0;
      logic ok;
      logic [7:0] exp_byte;

      vecs[0] = '{1'b1, OP_LOW,   6'd2, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{1'b1, OP_HIGH,  6'd5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{1'b1, OP_WRITE, 6'd3, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{1'b0, OP_WRITE, 6'd9, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      sweeps[0] = '{2,  5,  0, 4,  1'b0};
      sweeps[1] = '{7,  7,  0, 1,  1'b0};
      sweeps[2] = '{0,  63, 0, 64, 1'b0};
      sweeps[3] = '{62, 1,  0, 4,  1'b0};
      sweeps[4] = '{2,  5,  3, 2,  1'b1};

      req_if.req_valid = 1'b0;
      req_if.req_op    = OP_WRITE;

      // Reset held for two edges with busy initially set
      step();
      @(negedge clock);
      check("rst clr_busy", clr_busy, 1);
      check("rst req_ready", req_if.req_ready, 0);
      check("rst done", done, 0);
      check("rst set_busy", set_busy, 0);
      step();
      @(negedge clock);
      check("rst busy cleared", busy, 0);
      step();
      reset_n = 1'b1;
      @(negedge clock);
      check("post-rst req_ready", req_if.req_ready, 1);
      check("post-rst zero_cnt", zero_cnt, 0);
      check("post-rst aborted", aborted, 0);
      check("post-rst clr_busy", clr_busy, 0);
      step();

      // Back-to-back single-cycle commands from the vector table
      for (int i = 0; i < 4; i++) begin
         req_if.req_valid = vecs[i].valid;
         req_if.req_op    = vecs[i].op;
         addr             = vecs[i].a;
         din              = vecs[i].d;
         abort            = vecs[i].ab;
         @(negedge clock);
         check($sformatf("vec%0d ld_low", i), ld_low, vecs[i].e_low);
         check($sformatf("vec%0d ld_high", i), ld_high, vecs[i].e_high);
         check($sformatf("vec%0d write", i), write, vecs[i].e_write);
         check($sformatf("vec%0d req_ready", i), req_if.req_ready, vecs[i].e_ready);
         check($sformatf("vec%0d ld_cnt", i), ld_cnt, 0);
         check($sformatf("vec%0d addr_sel", i), addr_sel, 0);
         step();
      end
      req_if.req_valid = 1'b0;
      abort            = 1'b0;
      check("mem[3] after write", mem[3], 8'hA5);
      check("low register", low_reg, 2);
      check("high register", high_reg, 5);

      // Sweeps: normal, single word, full range, wrap, abort
      for (int s = 0; s < 5; s++) begin
         fill_req = 1'b1;
         step();
         fill_req = 1'b0;
         req_if.req_valid = 1'b1;
         req_if.req_op    = OP_LOW;
         addr             = AW'(sweeps[s].low);
         step();
         req_if.req_op    = OP_HIGH;
         addr             = AW'(sweeps[s].high);
         step();
         req_if.req_op    = OP_ZERO;
         @(negedge clock);
         check($sformatf("sweep%0d ld_cnt", s), ld_cnt, 1);
         check($sformatf("sweep%0d set_busy", s), set_busy, 1);
         sb.push_back('{sweeps[s].writes, sweeps[s].ab,
                        cyc + ((sweeps[s].abort_at != 0) ? sweeps[s].abort_at + 1
                                                          : sweeps[s].writes + 1)});
         step();
         // T1: a command offered now must be ignored
         req_if.req_valid = (sweeps[s].abort_at != 0);
         req_if.req_op    = OP_LOW;
         addr             = 6'd40;
         abort            = (sweeps[s].abort_at == 1);
         @(negedge clock);
         check($sformatf("sweep%0d T1 addr_sel", s), addr_sel, 1);
         check($sformatf("sweep%0d T1 req_ready", s), req_if.req_ready, 0);
         check($sformatf("sweep%0d T1 ld_low", s), ld_low, 0);
         check($sformatf("sweep%0d T1 busy", s), busy, 1);
         for (int j = 2; j <= sweeps[s].abort_at; j++) begin
            step();
            req_if.req_valid = 1'b0;
            abort            = (j == sweeps[s].abort_at);
         end
         step();
         req_if.req_valid = 1'b0;
         abort            = 1'b0;
         ok = 1'b0;
         for (int t = 0; t < 100; t++) begin
            @(negedge clock);
            if (req_if.req_ready) begin
               ok = 1'b1;
               break;
            end
         end
         check($sformatf("sweep%0d completes", s), ok, 1);
         check($sformatf("sweep%0d busy after", s), busy, 0);
         check($sformatf("sweep%0d zero_cnt held", s), zero_cnt, sweeps[s].writes);
         bad = 0;
         for (int a = 0; a < DEPTH; a++) begin
            off      = (a - sweeps[s].low + DEPTH) % DEPTH;
            exp_byte = (off < sweeps[s].writes) ? 8'h00 : 8'hFF;
            if (mem[a] !== exp_byte) bad++;
         end
         check($sformatf("sweep%0d memory image bad words", s), bad, 0);
         step();
      end

      // Reset in the middle of a 2..5 sweep
      fill_req = 1'b1;
      step();
      fill_req = 1'b0;
      req_if.req_valid = 1'b1;
      req_if.req_op    = OP_LOW;
      addr             = 6'd2;
      step();
      req_if.req_op    = OP_HIGH;
      addr             = 6'd5;
      step();
      req_if.req_op    = OP_ZERO;
      step();
      req_if.req_valid = 1'b0;
      step();
      reset_n = 1'b0;
      d0      = done_seen;
      @(negedge clock);
      check("mid-rst clr_busy", clr_busy, 1);
      check("mid-rst zero_we", zero_we, 0);
      check("mid-rst req_ready", req_if.req_ready, 0);
      check("mid-rst done", done, 0);
      step();
      step();
      reset_n = 1'b1;
      @(negedge clock);
      check("mid-rst idle ready", req_if.req_ready, 1);
      check("mid-rst busy", busy, 0);
      check("mid-rst zero_cnt", zero_cnt, 0);
      check("mid-rst mem[2] stays zero", mem[2], 8'h00);
      check("mid-rst mem[3] untouched", mem[3], 8'hFF);
      step();
      step();
      check("mid-rst no done", done_seen, d0);

      check("scoreboard drained", sb.size(), 0);
      check("done pulse count", done_seen, 5);
      check("set/clr busy overlap", both_seen, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard time limit so the bench can never hang
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_clear_ctrl.md
Name: mem_clear_ctrl

Overview:
- Controller that sequences the address-range memory datapath: loads its low/high address registers, issues single writes, and runs the zero-fill sweep.
- Accepts one command at a time over a valid/ready handshake and drives every datapath control strobe.
- Reads back only cnt_eq and owns the busy JK flip-flop through set_busy/clr_busy.
- addr and din go straight to the datapath; this block never touches them.

Parameters:
ADDRWIDTH, 6, datapath address width; sets zero_cnt width and the maximum sweep length of 2**ADDRWIDTH.

Ports:
- clock  in  1  rising-edge clock, shared with the datapath.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  command present.
- req_op  in  2  command: 00 WRITE, 01 LOAD_LOW, 10 LOAD_HIGH, 11 ZERO_RANGE.
- req_ready  out  1  controller can accept a command this cycle.
- abort  in  1  terminates an active sweep.
- cnt_eq  in  1  datapath flag: counter equals the high register.
- ld_low  out  1  datapath low-register load strobe.
- ld_high  out  1  datapath high-register load strobe.
- write  out  1  datapath host write enable.
- ld_cnt  out  1  loads the datapath counter from the low register.
- cnt_en  out  1  datapath counter increment.
- addr_sel  out  1  0 = host addr/din, 1 = counter address with zero data.
- zero_we  out  1  datapath sweep write enable.
- set_busy  out  1  busy JK flip-flop J input.
- clr_busy  out  1  busy JK flip-flop K input.
- done  out  1  one-cycle pulse when a sweep ends, normally or by abort.
- aborted  out  1  registered; 1 if the last sweep ended by abort.
- zero_cnt  out  ADDRWIDTH+1  registered count of zero writes performed by the last sweep.

Behaviour:
- States: IDLE, ZERO, DONE. All control outputs are combinational from state and inputs (Mealy); state, aborted and zero_cnt are registered.
- Reset (reset_n=0 at an edge):
  - state goes to IDLE; aborted and zero_cnt go to 0.
  - While reset_n=0, clr_busy=1 and all other outputs are 0, including req_ready and done. The busy flip-flop therefore clears during reset.
  - Reset asserted mid-sweep abandons the sweep with no done pulse. Already-zeroed words stay zeroed.
- req_ready = 1 only in IDLE with reset_n=1. A command is accepted on a cycle where req_valid & req_ready.
- Accepted WRITE: write=1 in the accept cycle; the memory writes din at addr on that edge. Stay in IDLE.
- Accepted LOAD_LOW / LOAD_HIGH: ld_low / ld_high = 1 for the accept cycle only. Stay in IDLE.
- Single-cycle commands may be issued back-to-back every cycle.
- Accepted ZERO_RANGE, in the accept cycle:
  - ld_cnt=1 and set_busy=1;
  - zero_cnt is cleared to 0 and aborted to 0;
  - next state is ZERO.
- ZERO state:
  - addr_sel=1.
  - If abort=1: zero_we=0, cnt_en=0, aborted is set to 1, next state DONE. Abort takes priority over cnt_eq.
  - Otherwise: zero_we=1 and zero_cnt increments.
    - cnt_eq=0: cnt_en=1, stay in ZERO.
    - cnt_eq=1: cnt_en=0, next state DONE.
  - The sweep is inclusive of both low and high.
- DONE state: clr_busy=1, done=1, addr_sel=0, next state IDLE. req_ready=0 in DONE.
- Latency for a sweep of N words with no abort:
  - accept at cycle T0;
  - writes in cycles T1..TN;
  - done in cycle TN+1;
  - req_ready returns high in cycle TN+2.
- Boundary cases:
  - low == high: exactly 1 write.
  - low > high: the counter wraps modulo 2**ADDRWIDTH, giving 2**ADDRWIDTH - low + high + 1 writes.
  - low=0, high=2**ADDRWIDTH-1: 2**ADDRWIDTH writes. zero_cnt must hold this value without overflow.
- abort outside ZERO is ignored. req_valid outside IDLE is ignored, and the command is not accepted.
- set_busy and clr_busy are never both 1.

Test Plan:
- Reset with busy previously 1: hold reset_n=0 for 2 cycles -> clr_busy=1, busy=0, req_ready=0; after release req_ready=1, zero_cnt=0.
- Single-cycle commands: LOAD_LOW addr=2, then LOAD_HIGH addr=5, then WRITE addr=3 din=8'hA5 on consecutive cycles -> ld_low, ld_high and write each pulse 1 cycle; mem[3]=A5; req_ready stays 1.
- Normal sweep: mem all FF, low=2, high=5, ZERO_RANGE -> writes at cycles T1..T4 to addresses 2..5; done at T5; zero_cnt=4; aborted=0; busy 1 from T1 to T5 and 0 after; mem[1]=FF, mem[6]=FF.
- Degenerate and full ranges:
  - low=high=7 -> 1 write, zero_cnt=1, done at T2;
  - low=0, high=63 -> 64 writes, zero_cnt=64.
- Wrap: low=62, high=1 -> addresses 62, 63, 0, 1 zeroed; zero_cnt=4; mem[2] and mem[61] untouched.
- Abort and reset:
  - abort at T3 of a 2..5 sweep -> only addresses 2 and 3 zeroed, zero_cnt=2, aborted=1, done pulse once.
  - reset_n=0 during ZERO -> IDLE with no done pulse and busy=0.
